// File: rtl/run_det_pkg.sv
// Shared index helpers and mode encoding for the run-length detector.
package run_det_pkg;

   localparam logic MODE_SATURATE = 1'b0;
   localparam logic MODE_RESTART  = 1'b1;

   function automatic int idx_idle();
      return 0;
   endfunction

   function automatic int idx_z(input int k);
      return k;
   endfunction

   function automatic int idx_o(input int run_len, input int k);
      return run_len + k;
   endfunction

endpackage

// File: rtl/run_length_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/run_length_detector.sv
// Moore one-hot detector for RUN_LEN equal consecutive samples of w.
// Optional one-hot self-check: define RUN_LENGTH_DETECTOR_ONEHOT_CHECK_EN.
//
// state      | meaning
// IDLE  (0)  | no sample seen since reset / recovery
// Zk    (k)  | k consecutive zeros seen, k = 1..RUN_LEN
// Ok (RL+k)  | k consecutive ones seen,  k = 1..RUN_LEN
module run_length_detector
   import run_det_pkg::*;
#(
   parameter int RUN_LEN = 4,
   parameter int CNT_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 w,
   input  logic                 mode_restart,
   input  logic                 clr_cnt,
   output logic [2*RUN_LEN:0]   state,
   output logic                 z,
   output logic                 z_zero,
   output logic                 z_one,
   output logic [CNT_W-1:0]     det_cnt,
   output logic                 err
);

   localparam int NS   = 2*RUN_LEN + 1;
   localparam int I_ZR = idx_z(RUN_LEN);
   localparam int I_OR = idx_o(RUN_LEN, RUN_LEN);
   localparam int I_O1 = idx_o(RUN_LEN, 1);
   localparam logic [NS-1:0] ST_IDLE = NS'(1) << idx_idle();

   logic [NS-1:0] state_q, state_d;
   logic          restart;
   logic          illegal;
   logic          det_inc;

   assign restart = (mode_restart == MODE_RESTART);

   always_comb begin
      state_d = state_q;
      illegal = 1'b0;
      if (en) begin
         state_d = '0;
         for (int k = 2; k <= RUN_LEN; k++) begin
            state_d[idx_z(k)]          = ~w & state_q[idx_z(k-1)];
            state_d[idx_o(RUN_LEN, k)] =  w & state_q[idx_o(RUN_LEN, k-1)];
         end
         // Terminal states either hold (saturate) or fold back to the first step.
         state_d[I_ZR] = state_d[I_ZR] | (~w & ~restart & state_q[I_ZR]);
         state_d[I_OR] = state_d[I_OR] | ( w & ~restart & state_q[I_OR]);
         state_d[idx_z(1)] = ~w & (state_q[idx_idle()] | (|state_q[I_OR:I_O1])
                                   | (restart & state_q[I_ZR]));
         state_d[I_O1]     =  w & (state_q[idx_idle()] | (|state_q[I_ZR:idx_z(1)])
                                   | (restart & state_q[I_OR]));
      end
`ifdef RUN_LENGTH_DETECTOR_ONEHOT_CHECK_EN
      illegal = (state_q == '0) ||
                ((state_q & (state_q - {{(NS-1){1'b0}}, 1'b1})) != '0);
      if (illegal)
         state_d = ST_IDLE;
`endif
   end

   assign det_inc = ((state_d[I_ZR] & ~state_q[I_ZR]) |
                     (state_d[I_OR] & ~state_q[I_OR])) & ~illegal;

   always_ff @(posedge clk) begin
      if (!rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

`ifdef RUN_LENGTH_DETECTOR_ONEHOT_CHECK_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (!rst)
         err_q <= 1'b0;
      else
         err_q <= illegal;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   sat_counter #(.CNT_W(CNT_W)) u_det_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr_cnt),
      .inc (det_inc),
      .cnt (det_cnt)
   );

   assign state  = state_q;
   assign z_zero = state_q[I_ZR];
   assign z_one  = state_q[I_OR];
   assign z      = z_zero | z_one;

endmodule
